lsu_ctrl: RTL and testbench

Load/store controller between the execute stage and the word-wide synchronous data memory (`data_mem`). It accepts one byte, halfword or word access at a time and drives the single memory port. It performs read-modify-write for SB/SH, and byte-lane selection with sign/zero extension for loads. It reports misaligned or illegal accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_ctrl_if.sv | 29 ++
 rtl/lsu_lane.sv | 40 ++++
 rtl/lsu_ctrl.sv | 120 ++++++++++++
 tb/tb_lsu_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states
// and the alignment/legality rule applied at request accept.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RMW  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Unsigned variants exist only for loads; stores stop at SW.
    function automatic logic legal_access(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-stage request/response handshake plus the single data memory port.
// The master side is the environment (execute stage and data_mem together).
interface lsu_ctrl_if #(parameter int ADDR_WIDTH = 10);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [31:0]           mem_wd;
    logic [31:0]           mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_a, mem_wd
    );

endinterface

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic shared by the load path (select + extend) and the
// read-modify-write path (merge store data into the old word).
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (addr_lo[1]) store_word[31:16] = wdata;
                else            store_word[15:0]  = wdata;
            end
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access at a time on a word-wide synchronous
// memory, with RMW for sub-word stores and error reporting for bad accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus
);

    state_t                state_q, state_d;
    logic                  err_q, err_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;

    logic                  accept;
    logic                  legal;
    logic [31:0]           lane_load;
    logic [31:0]           lane_store;
    logic                  unused_addr_hi;

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign accept         = bus.req_valid && bus.req_ready;
    assign legal          = legal_access(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    // Byte addresses beyond the memory alias onto it.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_WIDTH+2];

    lsu_lane u_lane (
        .word       (bus.mem_rd),
        .wdata      (wdata_q),
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.mem_we     = 1'b0;
        bus.mem_a      = addr_q[ADDR_WIDTH+1:2];
        bus.mem_wd     = 32'd0;

        case (state_q)
            S_IDLE: begin
                bus.mem_a = bus.req_addr[ADDR_WIDTH+1:2];
                if (accept) begin
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr[ADDR_WIDTH+1:0];
                    wdata_d  = bus.req_wdata[15:0];
                    err_d    = !legal;
                    if (!legal) begin
                        state_d = S_RESP;
                    end else if (!bus.req_we) begin
                        state_d = S_LOAD;
                    end else if (bus.req_funct3 == F3_W) begin
                        bus.mem_we = 1'b1;
                        bus.mem_wd = bus.req_wdata;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_RMW;
                    end
                end
            end
            S_LOAD: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = lane_load;
                state_d        = S_IDLE;
            end
            S_RMW: begin
                bus.mem_we = 1'b1;
                bus.mem_wd = lane_store;
                state_d    = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset silences the port, which also drops an in-flight RMW write.
        if (rst) begin
            bus.resp_valid = 1'b0;
            bus.resp_err   = 1'b0;
            bus.resp_rdata = 32'd0;
            bus.mem_we     = 1'b0;
            bus.mem_a      = '0;
            bus.mem_wd     = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed table, reset/throughput sequences and random
// accesses against a byte-lane reference model of the data memory.
module tb_lsu_ctrl;

    localparam int AW = 10;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] dmem    [1024];
    logic [31:0] ref_mem [1024];

    lsu_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    lsu_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // data_mem: registered read, read-before-write.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
            bus.mem_rd <= 32'd0;
        end else begin
            if (bus.mem_we) dmem[bus.mem_a] <= bus.mem_wd;
            bus.mem_rd <= dmem[bus.mem_a];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (addr % nbytes(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        longint unsigned w, v, span;
        int n;
        n    = nbytes(f3);
        w    = word;
        span = 64'd1 << (8 * n);
        v    = (w >> (8 * (addr % 4))) % span;
        if (!f3[2] && n < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
        longint unsigned mask, o, d, r;
        int sh;
        sh   = 8 * (addr % 4);
        mask = ((64'd1 << (8 * nbytes(f3))) - 1) << sh;
        o    = old;
        d    = wd;
        r    = (o & ~mask) | ((d << sh) & mask);
        return r[31:0];
    endfunction

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        logic [9:0]  wa;
        logic [31:0] merged;
        bit          legal, is_sw, is_rmw;
        wa     = addr[11:2];
        legal  = ref_legal(we, f3, addr);
        is_sw  = legal && we && (f3 == 3'b010);
        is_rmw = legal && we && !is_sw;

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        #1;
        chk("ready_at_accept", 32'(bus.req_ready), 32'd1);
        chk("mem_a_at_accept", 32'(bus.mem_a), 32'(wa));
        chk("mem_we_at_accept", 32'(bus.mem_we), 32'(is_sw));
        chk("mem_wd_at_accept", bus.mem_wd, is_sw ? wd : 32'd0);
        @(posedge clk);
        if (is_sw) ref_mem[wa] = wd;

        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr = $urandom(); bus.req_wdata = $urandom();
        #1;
        if (is_rmw) begin
            merged = ref_store(ref_mem[wa], f3, addr, wd);
            chk("rmw_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rmw_mem_we", 32'(bus.mem_we), 32'd1);
            chk("rmw_mem_a", 32'(bus.mem_a), 32'(wa));
            chk("rmw_mem_wd", bus.mem_wd, merged);
            chk("rmw_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            ref_mem[wa] = merged;
            @(negedge clk);
            #1;
        end
        chk("resp_no_write", 32'(bus.mem_we), 32'd0);
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("resp_ready", 32'(bus.req_ready), 32'd0);
    endtask

    vec_t        tbl [15];
    logic        tp_we [5];
    logic [2:0]  tp_f3 [5];
    logic [31:0] tp_addr [5];
    logic [31:0] tp_wd [5];
    int          pending [$];
    logic [13:0] ready_pat;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h14, 32'h8081_7F01, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 32'h15, 32'h0, 1'b0, 32'h0000_007F};
        tbl[2]  = '{1'b0, 3'b100, 32'h15, 32'h0, 1'b0, 32'h0000_007F};
        tbl[3]  = '{1'b0, 3'b001, 32'h16, 32'h0, 1'b0, 32'hFFFF_8081};
        tbl[4]  = '{1'b0, 3'b101, 32'h16, 32'h0, 1'b0, 32'h0000_8081};
        tbl[5]  = '{1'b1, 3'b000, 32'h17, 32'h0000_00AA, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'hAA81_7F01};
        tbl[7]  = '{1'b0, 3'b010, 32'h16, 32'h0, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 3'b001, 32'h15, 32'h1234_5678, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 3'b011, 32'h14, 32'hDEAD_BEEF, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 3'b110, 32'h14, 32'h0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 3'b101, 32'h17, 32'h0, 1'b1, 32'h0};
        tbl[12] = '{1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'hAA81_7F01};
        tbl[13] = '{1'b0, 3'b000, 32'h14, 32'h0, 1'b0, 32'h0000_0001};
        tbl[14] = '{1'b0, 3'b000, 32'h16, 32'h0, 1'b0, 32'hFFFF_FF81};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

        // Reset with a tempting SW on the bus: nothing may reach the port.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h14; bus.req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ctrl", {28'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_we}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_a", 32'(bus.mem_a), 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        bus.req_valid = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 15; i++)
            do_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].rd);

        // Reset landing in the RMW cycle of SH must drop the merged write.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h14; bus.req_wdata = 32'h0000_BEEF;
        #1;
        chk("sh_rst_accept_ready", 32'(bus.req_ready), 32'd1);
        chk("sh_rst_accept_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("sh_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("sh_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("sh_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("sh_rst_ready_after", 32'(bus.req_ready), 32'd1);
        chk("sh_rst_resp_after", 32'(bus.resp_valid), 32'd0);
        do_access(1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'hAA81_7F01);

        // Continuous req_valid, alternating loads and byte stores.
        tp_we[0] = 1'b0; tp_f3[0] = 3'b010; tp_addr[0] = 32'h14; tp_wd[0] = 32'h0;
        tp_we[1] = 1'b1; tp_f3[1] = 3'b000; tp_addr[1] = 32'h17; tp_wd[1] = 32'h0000_005A;
        tp_we[2] = 1'b0; tp_f3[2] = 3'b000; tp_addr[2] = 32'h17; tp_wd[2] = 32'h0;
        tp_we[3] = 1'b1; tp_f3[3] = 3'b000; tp_addr[3] = 32'h14; tp_wd[3] = 32'h0000_0033;
        tp_we[4] = 1'b0; tp_f3[4] = 3'b010; tp_addr[4] = 32'h14; tp_wd[4] = 32'h0;
        ready_pat = 14'b11_0100_1010_0101; // bit i = expected req_ready in cycle i
        begin
            int idx;
            bit acc;
            idx = 0;
            for (int cyc = 0; cyc < 14; cyc++) begin
                @(negedge clk);
                bus.req_valid = (idx < 5);
                if (idx < 5) begin
                    bus.req_we = tp_we[idx]; bus.req_funct3 = tp_f3[idx];
                    bus.req_addr = tp_addr[idx]; bus.req_wdata = tp_wd[idx];
                end
                #1;
                chk($sformatf("tp_ready_c%0d", cyc), 32'(bus.req_ready), 32'(ready_pat[cyc]));
                if (bus.resp_valid) begin
                    if (pending.size() == 0) begin
                        chk("tp_spurious_resp", 32'd1, 32'd0);
                    end else begin
                        int j;
                        logic [9:0] wa;
                        j  = pending.pop_front();
                        wa = tp_addr[j][11:2];
                        chk("tp_resp_err", 32'(bus.resp_err), 32'd0);
                        if (tp_we[j]) begin
                            ref_mem[wa] = ref_store(ref_mem[wa], tp_f3[j], tp_addr[j], tp_wd[j]);
                            chk("tp_store_rdata", bus.resp_rdata, 32'd0);
                        end else begin
                            chk($sformatf("tp_load_rdata%0d", j), bus.resp_rdata,
                                ref_load(ref_mem[wa], tp_f3[j], tp_addr[j]));
                        end
                    end
                end
                acc = bus.req_valid && bus.req_ready;
                @(posedge clk);
                if (acc) begin
                    pending.push_back(idx);
                    idx++;
                end
            end
            bus.req_valid = 1'b0;
            chk("tp_accepted", 32'(idx), 32'd5);
            chk("tp_pending", 32'(pending.size()), 32'd0);
        end

        // Random accesses, upper address bits random to exercise aliasing.
        for (int n = 0; n < 200; n++) begin
            logic        we, e;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd, r;
            r    = $urandom();
            addr = (r & 32'hFFFF_FFE0) | 32'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom();
            e    = !ref_legal(we, f3, addr);
            rd   = (e || we) ? 32'd0 : ref_load(ref_mem[addr[11:2]], f3, addr);
            do_access(we, f3, addr, wd, e, rd);
        end

        @(negedge clk);
        for (int i = 0; i < 8; i++)
            chk($sformatf("final_word%0d", i), dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
